// File: rtl/puf_crp_sampler.sv
// Challenge/launch sequencer for a 64-bit arbiter PUF that majority-votes
// NUM_SAMPLES evaluations of the 8-bit response into one pulsed CRP record.
module puf_crp_sampler #(
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned NUM_SAMPLES   = 7,
   parameter logic [63:0] CHAL_SEED     = 64'h19f6cf91b090ac77
) (
   input  logic        CLOCK_50,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic [63:0] puf_challenge,
   output logic        puf_signal,
   input  logic [7:0]  puf_response,
   output logic        crp_valid,
   output logic [63:0] crp_challenge,
   output logic [7:0]  crp_response,
   output logic [7:0]  crp_unstable,
   output logic [15:0] crp_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int unsigned PW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE_CYCLES - 1);
   localparam logic [3:0]  SAMPLE_LAST = 4'(NUM_SAMPLES - 1);
   localparam logic [3:0]  VOTE_HALF   = 4'(NUM_SAMPLES / 2);
   localparam logic [3:0]  VOTE_FULL   = 4'(NUM_SAMPLES);

   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ 64'hD800000000000000) : (s >> 1);
   endfunction

   state_t         r_state;
   state_t         w_next_state;
   logic [PW-1:0]  r_phase;
   logic [3:0]     r_sample;
   logic [3:0]     r_vote [8];
   logic           w_phase_last;
   logic           r_busy;
   logic           r_signal;
   logic           r_valid;
   logic [63:0]    r_lfsr;
   logic [63:0]    r_crp_chal;
   logic [7:0]     r_crp_resp;
   logic [7:0]     r_crp_unst;
   logic [15:0]    r_count;

   assign w_phase_last = (r_phase == PHASE_LAST);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next_state = S_LOW;
            else       w_next_state = S_IDLE;
         end
         S_LOW: begin
            if (w_phase_last) w_next_state = S_HIGH;
            else              w_next_state = S_LOW;
         end
         S_HIGH: begin
            if (w_phase_last) begin
               if (r_sample == SAMPLE_LAST) w_next_state = S_DONE;
               else                         w_next_state = S_LOW;
            end else begin
               w_next_state = S_HIGH;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_phase  <= '0;
         r_sample <= 4'd0;
         r_busy   <= 1'b0;
         r_signal <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_busy   <= (w_next_state != S_IDLE);
         r_signal <= (w_next_state == S_HIGH);
         r_valid  <= (w_next_state == S_DONE);
         if (r_state == S_IDLE || r_state == S_DONE || w_phase_last) r_phase <= '0;
         else                                                         r_phase <= r_phase + PW'(1);
         if (r_state == S_IDLE && start)                 r_sample <= 4'd0;
         else if (r_state == S_HIGH && w_phase_last)     r_sample <= r_sample + 4'd1;
         else                                            r_sample <= r_sample;
      end
   end

   // Votes accumulate on the last HIGH cycle; the record and LFSR update in DONE.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) r_vote[i] <= 4'd0;
         r_lfsr     <= CHAL_SEED;
         r_crp_chal <= 64'd0;
         r_crp_resp <= 8'd0;
         r_crp_unst <= 8'd0;
         r_count    <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < 8; i++) r_vote[i] <= 4'd0;
               end
            end
            S_HIGH: begin
               if (w_phase_last) begin
                  for (int i = 0; i < 8; i++) r_vote[i] <= r_vote[i] + {3'b000, puf_response[i]};
               end
            end
            S_DONE: begin
               for (int i = 0; i < 8; i++) begin
                  r_crp_resp[i] <= (r_vote[i] > VOTE_HALF);
                  r_crp_unst[i] <= (r_vote[i] != 4'd0) && (r_vote[i] != VOTE_FULL);
               end
               r_crp_chal <= r_lfsr;
               r_count    <= r_count + 16'd1;
               r_lfsr     <= lfsr_step(r_lfsr);
            end
            default: begin
            end
         endcase
      end
   end

   assign busy          = r_busy;
   assign puf_signal    = r_signal;
   assign puf_challenge = r_lfsr;
   assign crp_valid     = r_valid;
   assign crp_challenge = r_crp_chal;
   assign crp_response  = r_crp_resp;
   assign crp_unstable  = r_crp_unst;
   assign crp_count     = r_count;

endmodule

// File: tb/tb_puf_crp_sampler.sv
// Directed bench for puf_crp_sampler: behavioural PUF model, record scoreboard,
// plus a fast S=1/N=1 instance for back-to-back period and count checks.
module tb_puf_crp_sampler;

   localparam logic [63:0] SEED = 64'h19f6cf91b090ac77;
   localparam int LAT    = 2 * 8 * 7 + 1;
   localparam int PERIOD = 2 * 8 * 7 + 2;

   typedef struct packed {
      logic [63:0] chal;
      logic [7:0]  resp;
      logic [7:0]  unst;
      logic [15:0] cnt;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        start2;
   logic        busy, busy2;
   logic [63:0] puf_challenge, puf_challenge2;
   logic        puf_signal, puf_signal2;
   logic [7:0]  puf_response, puf_response2;
   logic        crp_valid, crp_valid2;
   logic [63:0] crp_challenge, crp_challenge2;
   logic [7:0]  crp_response, crp_response2;
   logic [7:0]  crp_unstable, crp_unstable2;
   logic [15:0] crp_count, crp_count2;

   int   cyc = 0;
   int   puf_falls = 0;
   int   sample_base = 0;
   logic noisy = 1'b0;
   int   chal_viol = 0;
   logic last_sig = 1'b0;
   logic [63:0] last_chal = 64'd0;
   int   tests = 0;
   int   fails = 0;
   rec_t sb[$];

   always #5 clk = ~clk;

   puf_crp_sampler dut (
      .CLOCK_50(clk), .rst(rst), .start(start), .busy(busy),
      .puf_challenge(puf_challenge), .puf_signal(puf_signal), .puf_response(puf_response),
      .crp_valid(crp_valid), .crp_challenge(crp_challenge), .crp_response(crp_response),
      .crp_unstable(crp_unstable), .crp_count(crp_count)
   );

   puf_crp_sampler #(.SETTLE_CYCLES(1), .NUM_SAMPLES(1)) dut2 (
      .CLOCK_50(clk), .rst(rst), .start(start2), .busy(busy2),
      .puf_challenge(puf_challenge2), .puf_signal(puf_signal2), .puf_response(puf_response2),
      .crp_valid(crp_valid2), .crp_challenge(crp_challenge2), .crp_response(crp_response2),
      .crp_unstable(crp_unstable2), .crp_count(crp_count2)
   );

   function automatic logic [63:0] lfsr_next(input logic [63:0] s);
      logic [63:0] t;
      t = {1'b0, s[63:1]};
      if (s[0]) t = t ^ 64'hD800000000000000;
      return t;
   endfunction

   // Sample n of the current CRP sees pattern n; bit0 minority-1, bit7 majority-1 when noisy.
   function automatic logic [7:0] model(input int n, input logic nz);
      logic [7:0] v;
      v = 8'hA5;
      if (nz) begin
         v[0] = (n == 1 || n == 3 || n == 5);
         v[7] = !(n == 0 || n == 2);
      end
      return v;
   endfunction

   assign puf_response  = puf_signal  ? model(puf_falls - sample_base, noisy) : 8'h00;
   assign puf_response2 = puf_signal2 ? 8'h3C : 8'h00;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge puf_signal) puf_falls <= puf_falls + 1;

   always @(negedge clk) begin
      if (puf_signal === 1'b1 && last_sig === 1'b1 && puf_challenge !== last_chal)
         chal_viol <= chal_viol + 1;
      last_sig  <= puf_signal;
      last_chal <= puf_challenge;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int budget, output int vc);
      vc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (crp_valid === 1'b1) begin
            vc = cyc;
            break;
         end
      end
   endtask

   task automatic pulse_start(output int c);
      @(negedge clk);
      sample_base = puf_falls;
      start = 1'b1;
      c = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_record(input string tag);
      rec_t e;
      @(posedge clk);
      #1;
      chk({tag, "_sb"}, 64'(sb.size()), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_chal"}, crp_challenge, e.chal);
         chk({tag, "_resp"}, 64'(crp_response), 64'(e.resp));
         chk({tag, "_unst"}, 64'(crp_unstable), 64'(e.unst));
         chk({tag, "_cnt"}, 64'(crp_count), 64'(e.cnt));
         chk({tag, "_next_chal"}, puf_challenge, lfsr_next(e.chal));
      end
      chk({tag, "_valid_low"}, 64'(crp_valid), 64'd0);
      chk({tag, "_busy_low"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int c, vc, prev, edges;
      logic saw_busy;
      logic [63:0] exp_chal, exp_chal2;
      logic        prev_sig;

      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sig", 64'(puf_signal), 64'd0);
      chk("rst_valid", 64'(crp_valid), 64'd0);
      chk("rst_chal", puf_challenge, SEED);
      chk("rst_crp_chal", crp_challenge, 64'd0);
      chk("rst_resp", 64'(crp_response), 64'd0);
      chk("rst_unst", 64'(crp_unstable), 64'd0);
      chk("rst_cnt", 64'(crp_count), 64'd0);
      rst = 1'b0;
      saw_busy = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || crp_valid !== 1'b0) saw_busy = 1'b1;
      end
      chk("idle_quiet", 64'(saw_busy), 64'd0);

      // Stable response, with a stray start mid-run that must be dropped.
      exp_chal = SEED;
      pulse_start(c);
      sb.push_back('{chal: exp_chal, resp: 8'hA5, unst: 8'h00, cnt: 16'd1});
      repeat (30) @(negedge clk);
      chk("busy_mid", 64'(busy), 64'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(200, vc);
      chk("stable_lat", 64'(vc), 64'(c + LAT));
      check_record("stable");
      exp_chal = lfsr_next(exp_chal);
      saw_busy = 1'b0;
      repeat (120) begin
         @(negedge clk);
         if (busy !== 1'b0) saw_busy = 1'b1;
      end
      chk("stray_start_ignored", 64'(saw_busy), 64'd0);

      noisy = 1'b1;
      pulse_start(c);
      sb.push_back('{chal: exp_chal, resp: 8'hA4, unst: 8'h81, cnt: 16'd2});
      wait_valid(200, vc);
      chk("noisy_lat", 64'(vc), 64'(c + LAT));
      check_record("noisy");
      noisy = 1'b0;

      // Continuous run from a fresh reset.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_chal = SEED;
      @(negedge clk);
      start = 1'b1;
      c = cyc;
      prev = c + LAT - PERIOD;
      for (int n = 1; n <= 3; n++) begin
         sb.push_back('{chal: exp_chal, resp: 8'hA5, unst: 8'h00, cnt: 16'(n)});
         wait_valid(200, vc);
         chk($sformatf("cont%0d_period", n), 64'(vc), 64'(prev + PERIOD));
         prev = vc;
         check_record($sformatf("cont%0d", n));
         exp_chal = lfsr_next(exp_chal);
      end
      @(negedge clk);
      start = 1'b0;
      chk("chal_stable_high", 64'(chal_viol), 64'd0);

      // Reset during the third HIGH phase.
      pulse_start(c);
      edges = 0;
      prev_sig = puf_signal;
      for (int i = 0; i < 200 && edges < 3; i++) begin
         @(negedge clk);
         if (puf_signal === 1'b1 && prev_sig === 1'b0) edges++;
         prev_sig = puf_signal;
      end
      repeat (2) @(negedge clk);
      chk("third_high", 64'(puf_signal), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_sig", 64'(puf_signal), 64'd0);
      chk("async_busy", 64'(busy), 64'd0);
      chk("async_cnt", 64'(crp_count), 64'd0);
      chk("async_chal", puf_challenge, SEED);
      repeat (2) @(negedge clk);
      chk("rst_no_valid", 64'(crp_valid), 64'd0);
      rst = 1'b0;
      sample_base = puf_falls;
      start = 1'b1;
      c = cyc;
      @(negedge clk);
      start = 1'b0;
      sb.push_back('{chal: SEED, resp: 8'hA5, unst: 8'h00, cnt: 16'd1});
      wait_valid(200, vc);
      chk("post_rst_lat", 64'(vc), 64'(c + LAT));
      check_record("post_rst");

      // Fast instance: back-to-back CRPs every 4 cycles.
      exp_chal2 = SEED;
      @(negedge clk);
      start2 = 1'b1;
      prev = cyc - 1;
      for (int n = 1; n <= 20; n++) begin
         vc = -1;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (crp_valid2 === 1'b1) begin
               vc = cyc;
               break;
            end
         end
         chk($sformatf("fast%0d_period", n), 64'(vc), 64'(prev + 4));
         prev = vc;
         @(posedge clk);
         #1;
         chk($sformatf("fast%0d_cnt", n), 64'(crp_count2), 64'(n));
         chk($sformatf("fast%0d_resp", n), 64'(crp_response2), 64'h3C);
         chk($sformatf("fast%0d_chal", n), crp_challenge2, exp_chal2);
         exp_chal2 = lfsr_next(exp_chal2);
      end
      start2 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/puf_crp_sampler.md
# puf_crp_sampler

Drives the 64-bit arbiter PUF and produces one reliable challenge-response pair (CRP) per request. It sits on both sides of `arbiterpuf`:
- upstream, it generates the challenge and the launch signal;
- downstream, it captures the 8-bit response repeatedly and majority-votes it.

Each result comes out as a pulsed CRP record with a per-bit instability mask. The record feeds the display/LED logic or a later CRP logger.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 8: cycles per launch half-phase (low, then high). Legal range ≥1.
- `NUM_SAMPLES`, default 7: PUF evaluations per CRP. Must be odd, 1..15.
- `CHAL_SEED`, default 64'h19f6cf91b090ac77: LFSR reset value. Must be nonzero.

Ports:
- `CLOCK_50` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request one CRP evaluation. Sampled only in IDLE.
- `busy` out 1: high while an evaluation is in progress, including the DONE cycle.
- `puf_challenge` out 64: to the PUF challenge input.
- `puf_signal` out 1: to the PUF launch input.
- `puf_response` in 8: from the PUF response output.
- `crp_valid` out 1: one-cycle pulse; the record is valid in this cycle.
- `crp_challenge` out 64: challenge used for the record.
- `crp_response` out 8: majority-voted response.
- `crp_unstable` out 8: 1 for any bit whose votes were not unanimous.
- `crp_count` out 16: number of completed CRPs. Wraps from 65535 to 0.

## Operation
- FSM states are IDLE, LOW, HIGH and DONE. A sample counter runs 0..NUM_SAMPLES-1 and a phase counter runs 0..SETTLE_CYCLES-1.
- IDLE:
  - `puf_signal`=0, `busy`=0.
  - `start`=1 moves to LOW and clears the per-bit vote counters and the sample counter.
- LOW:
  - `puf_signal`=0 for SETTLE_CYCLES cycles, then go to HIGH.
- HIGH:
  - `puf_signal`=1 for SETTLE_CYCLES cycles.
  - On the last HIGH cycle, add `puf_response[i]` into vote counter i. Each counter is 4 bits wide.
  - If fewer than NUM_SAMPLES samples have been taken, return to LOW; otherwise go to DONE.
- DONE (one cycle):
  - `crp_valid`=1.
  - `crp_response[i]` = (vote_i > NUM_SAMPLES/2).
  - `crp_unstable[i]` = (vote_i != 0 && vote_i != NUM_SAMPLES).
  - `crp_challenge` = current `puf_challenge`.
  - `crp_count` increments.
  - The LFSR advances one step.
  - Next state is IDLE.
- LFSR:
  - 64-bit Galois, right-shift form.
  - Step: if lsb=1, next = (s>>1) ^ 64'hD800000000000000; otherwise next = s>>1.
  - Advances only in DONE.
- `puf_challenge` is constant from entry into LOW through DONE. The PUF never sees a challenge change during a race.
- `start` asserted outside IDLE is ignored and is not queued.
- `crp_challenge`, `crp_response` and `crp_unstable` hold their value between pulses.

## Timing
- Reset values:
  - `busy`=0, `puf_signal`=0, `crp_valid`=0.
  - `puf_challenge`=CHAL_SEED.
  - `crp_challenge`=0, `crp_response`=0, `crp_unstable`=0, `crp_count`=0.
  - FSM in IDLE, vote counters 0.
- `start` is sampled high at edge k in IDLE:
  - LOW occupies cycles k+1 .. k+S.
  - HIGH occupies cycles k+S+1 .. k+2S.
  - Sample n is taken at the edge ending cycle k+2S(n+1).
- `crp_valid` is high in cycle k+1+2·S·N. With the defaults that is k+113.
- Updated record outputs and the new `puf_challenge` are visible from the DONE cycle's closing edge onward.
- With `start` held high, back-to-back period is 2·S·N+2 cycles (DONE plus one IDLE cycle). Default period: 114 cycles.
- `rst` mid-operation:
  - All state and outputs return to reset values immediately (asynchronous).
  - No `crp_valid` pulse is produced.
  - The LFSR restarts from CHAL_SEED.
- Release of `rst` takes effect at the next rising edge. A `start` seen on that edge is accepted.

## Test plan
- **Reset values:** assert `rst` for 3 cycles with `start`=0 → all outputs at reset values; `puf_challenge`=64'h19f6cf91b090ac77; `busy`=0 for 20 further cycles.
- **Stable response:** bench PUF model returns 8'hA5 whenever `puf_signal`=1. Pulse `start` at edge k →
  - `crp_valid` exactly in cycle k+113;
  - `crp_response`=8'hA5, `crp_unstable`=8'h00, `crp_challenge`=seed, `crp_count`=1;
  - `puf_challenge` equals the bench-computed LFSR step of the seed.
- **Noisy bits:** model returns 8'hA5, except bit0 reads 1 on samples 1, 3, 5 and bit7 reads 0 on samples 0, 2 → `crp_response`=8'hA4, `crp_unstable`=8'h81.
- **Continuous run:** hold `start`=1 →
  - `crp_valid` pulses every 114 cycles; `crp_count` reads 1, 2, 3;
  - each `crp_challenge` equals the previous `puf_challenge` advanced once;
  - `puf_challenge` never changes while `puf_signal`=1.
- **Reset mid-run:** assert `rst` during the third HIGH phase →
  - `puf_signal`, `busy` and `crp_count` go to 0 without waiting for a clock edge;
  - no `crp_valid` pulse;
  - after release, the next CRP reports `crp_challenge`=seed.
- **Count wrap:** with SETTLE_CYCLES=1 and NUM_SAMPLES=1, hold `start`=1 for 65537 CRPs → `crp_count` sequence …65535, 0, 1; the period is 4 cycles throughout.
